// File: rtl/gelato_collector_dispatch.sv
// gelato_collector_dispatch
//   Drain side of the operand collector. Accepts one fully collected entry
//   (op, warp, rd, thread mask, three warp-wide operands) and emits one ALU
//   task per lane group that has at least one active thread, in ascending
//   group order, with empty groups skipped.
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   in_valid / in_ready           entry handshake; in_ready is high in IDLE only
//   in_op, in_warp_num, in_rd     instruction info
//   in_mask                       thread mask of the instruction
//   in_rs1/2/3                    warp operands, thread t at [t*DW +: DW]
//   out_valid / out_ready         ALU task handshake
//   out_op, out_warp_num, out_rd  captured instruction info
//   out_group, out_lane_mask      group index and its mask slice
//   out_rs1/2/3                   lane operands, inactive lanes zeroed
//   out_last                      no further non-empty group in this entry
module gelato_collector_dispatch #(
  parameter int unsigned THREAD_NUM = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 8,
  parameter int unsigned WARP_W     = 5,
  parameter int unsigned REG_W      = 5,
  localparam int unsigned OP_W      = 5,
  localparam int unsigned GROUPS    = THREAD_NUM / LANES,
  localparam int unsigned GRP_W     = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [OP_W-1:0]                  in_op,
  input  logic [WARP_W-1:0]                in_warp_num,
  input  logic [REG_W-1:0]                 in_rd,
  input  logic [THREAD_NUM-1:0]            in_mask,
  input  logic [THREAD_NUM*DATA_WIDTH-1:0] in_rs1,
  input  logic [THREAD_NUM*DATA_WIDTH-1:0] in_rs2,
  input  logic [THREAD_NUM*DATA_WIDTH-1:0] in_rs3,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OP_W-1:0]                  out_op,
  output logic [WARP_W-1:0]                out_warp_num,
  output logic [REG_W-1:0]                 out_rd,
  output logic [GRP_W-1:0]                 out_group,
  output logic [LANES-1:0]                 out_lane_mask,
  output logic [LANES*DATA_WIDTH-1:0]      out_rs1,
  output logic [LANES*DATA_WIDTH-1:0]      out_rs2,
  output logic [LANES*DATA_WIDTH-1:0]      out_rs3,
  output logic                             out_last
);

  localparam int unsigned WARP_DW = THREAD_NUM * DATA_WIDTH;
  localparam int unsigned LANE_DW = LANES * DATA_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Captured entry
  logic [THREAD_NUM-1:0] mask_q, mask_d;
  logic [WARP_DW-1:0]    rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic [GROUPS-1:0]     nz_q, nz_d;

  // Task output registers
  logic [OP_W-1:0]    op_q, op_d;
  logic [WARP_W-1:0]  warp_q, warp_d;
  logic [REG_W-1:0]   rd_q, rd_d;
  logic [GRP_W-1:0]   group_q, group_d;
  logic [LANES-1:0]   lmask_q, lmask_d;
  logic [LANE_DW-1:0] ors1_q, ors1_d, ors2_q, ors2_d, ors3_q, ors3_d;
  logic               last_q, last_d;

  // Group search and slicing
  logic [GROUPS-1:0]     in_nz, src_nz, cand;
  logic [THREAD_NUM-1:0] src_mask, mask_sh;
  logic [WARP_DW-1:0]    src_rs1, src_rs2, src_rs3, rs1_sh, rs2_sh, rs3_sh;
  logic [GRP_W:0]        start;
  logic [GRP_W-1:0]      sel;
  logic                  found, more;
  logic [LANES-1:0]      sel_lmask;
  logic [LANE_DW-1:0]    sel_rs1, sel_rs2, sel_rs3;

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == ISSUE);
  assign out_op        = op_q;
  assign out_warp_num  = warp_q;
  assign out_rd        = rd_q;
  assign out_group     = group_q;
  assign out_lane_mask = lmask_q;
  assign out_rs1       = ors1_q;
  assign out_rs2       = ors2_q;
  assign out_rs3       = ors3_q;
  assign out_last      = last_q;

  // Next non-empty group: from the incoming entry when idle, else strictly above g
  always_comb begin
    for (int g = 0; g < int'(GROUPS); g++) begin
      in_nz[g] = |in_mask[g*LANES +: LANES];
    end
    if (state_q == IDLE) begin
      src_nz   = in_nz;
      src_mask = in_mask;
      src_rs1  = in_rs1;
      src_rs2  = in_rs2;
      src_rs3  = in_rs3;
      start    = '0;
    end else begin
      src_nz   = nz_q;
      src_mask = mask_q;
      src_rs1  = rs1_q;
      src_rs2  = rs2_q;
      src_rs3  = rs3_q;
      start    = (GRP_W+1)'(group_q) + (GRP_W+1)'(1);
    end
    cand  = src_nz & ({GROUPS{1'b1}} << start);
    found = |cand;
    sel   = '0;
    for (int i = int'(GROUPS) - 1; i >= 0; i--) begin
      if (cand[i]) sel = GRP_W'(i);
    end
    more = |(src_nz >> (32'(sel) + 32'd1));

    mask_sh   = src_mask >> (32'(sel) * LANES);
    rs1_sh    = src_rs1 >> (32'(sel) * LANE_DW);
    rs2_sh    = src_rs2 >> (32'(sel) * LANE_DW);
    rs3_sh    = src_rs3 >> (32'(sel) * LANE_DW);
    sel_lmask = mask_sh[LANES-1:0];
    sel_rs1   = '0;
    sel_rs2   = '0;
    sel_rs3   = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (sel_lmask[l]) begin
        sel_rs1[l*DATA_WIDTH +: DATA_WIDTH] = rs1_sh[l*DATA_WIDTH +: DATA_WIDTH];
        sel_rs2[l*DATA_WIDTH +: DATA_WIDTH] = rs2_sh[l*DATA_WIDTH +: DATA_WIDTH];
        sel_rs3[l*DATA_WIDTH +: DATA_WIDTH] = rs3_sh[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next state and task register loads
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rs3_d   = rs3_q;
    nz_d    = nz_q;
    op_d    = op_q;
    warp_d  = warp_q;
    rd_d    = rd_q;
    group_d = group_q;
    lmask_d = lmask_q;
    ors1_d  = ors1_q;
    ors2_d  = ors2_q;
    ors3_d  = ors3_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mask_d = in_mask;
          rs1_d  = in_rs1;
          rs2_d  = in_rs2;
          rs3_d  = in_rs3;
          nz_d   = in_nz;
          // An all-zero mask is consumed without emitting a task
          if (found) begin
            op_d    = in_op;
            warp_d  = in_warp_num;
            rd_d    = in_rd;
            group_d = sel;
            lmask_d = sel_lmask;
            ors1_d  = sel_rs1;
            ors2_d  = sel_rs2;
            ors3_d  = sel_rs3;
            last_d  = !more;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            group_d = sel;
            lmask_d = sel_lmask;
            ors1_d  = sel_rs1;
            ors2_d  = sel_rs2;
            ors3_d  = sel_rs3;
            last_d  = !more;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
      nz_q    <= '0;
      op_q    <= '0;
      warp_q  <= '0;
      rd_q    <= '0;
      group_q <= '0;
      lmask_q <= '0;
      ors1_q  <= '0;
      ors2_q  <= '0;
      ors3_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rs3_q   <= rs3_d;
      nz_q    <= nz_d;
      op_q    <= op_d;
      warp_q  <= warp_d;
      rd_q    <= rd_d;
      group_q <= group_d;
      lmask_q <= lmask_d;
      ors1_q  <= ors1_d;
      ors2_q  <= ors2_d;
      ors3_q  <= ors3_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_gelato_collector_dispatch.sv
// Testbench for gelato_collector_dispatch: accepted entries are expanded into
// expected ALU tasks by a reference model and queued; a negedge monitor pops
// and compares every handshaken task and checks handshake levels and stall
// stability.
module tb_gelato_collector_dispatch;

  localparam int TN = 32;
  localparam int DW = 32;
  localparam int L  = 8;
  localparam int G  = TN / L;

  logic            clk, rst;
  logic            in_valid, in_ready;
  logic [4:0]      in_op, in_warp_num, in_rd;
  logic [TN-1:0]   in_mask;
  logic [TN*DW-1:0] in_rs1, in_rs2, in_rs3;
  logic            out_valid, out_ready;
  logic [4:0]      out_op, out_warp_num, out_rd;
  logic [1:0]      out_group;
  logic [L-1:0]    out_lane_mask;
  logic [L*DW-1:0] out_rs1, out_rs2, out_rs3;
  logic            out_last;

  gelato_collector_dispatch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_warp_num(in_warp_num), .in_rd(in_rd), .in_mask(in_mask),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_warp_num(out_warp_num), .out_rd(out_rd),
    .out_group(out_group), .out_lane_mask(out_lane_mask),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
    .out_last(out_last)
  );

  typedef struct {
    logic [4:0]      op, warp, rd;
    logic [1:0]      grp;
    logic [L-1:0]    lmask;
    logic [L*DW-1:0] rs1, rs2, rs3;
    logic            last;
  } task_t;

  task_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  bit    rnd_ready = 0;
  bit    forced_ready = 0;

  bit          stall_prev = 0;
  logic [25:0] prev_ctl;
  logic [L*DW-1:0] prev_rs1, prev_rs2, prev_rs3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  function automatic logic [25:0] dut_ctl();
    return {out_op, out_warp_num, out_rd, out_group, out_lane_mask, out_last};
  endfunction

  // Reference model: one task per group with any active thread, ascending order
  task automatic model_push();
    task_t t;
    int    last_i = -1;
    for (int g = 0; g < G; g++) begin
      if (in_mask[g*L +: L] != '0) begin
        t.op = in_op; t.warp = in_warp_num; t.rd = in_rd;
        t.grp = 2'(g);
        t.lmask = in_mask[g*L +: L];
        for (int l = 0; l < L; l++) begin
          int th = g*L + l;
          t.rs1[l*DW +: DW] = in_mask[th] ? in_rs1[th*DW +: DW] : 32'd0;
          t.rs2[l*DW +: DW] = in_mask[th] ? in_rs2[th*DW +: DW] : 32'd0;
          t.rs3[l*DW +: DW] = in_mask[th] ? in_rs3[th*DW +: DW] : 32'd0;
        end
        t.last = 1'b0;
        exp_q.push_back(t);
        last_i = exp_q.size() - 1;
      end
    end
    if (last_i >= 0) exp_q[last_i].last = 1'b1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 0;
    end else begin
      check("out_valid", 256'(out_valid), 256'(exp_q.size() != 0));
      check("in_ready", 256'(in_ready), 256'(exp_q.size() == 0));
      if (stall_prev && out_valid) begin
        check("stall_ctl", 256'(dut_ctl()), 256'(prev_ctl));
        check("stall_rs1", out_rs1, prev_rs1);
        check("stall_rs2", out_rs2, prev_rs2);
        check("stall_rs3", out_rs3, prev_rs3);
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        task_t e;
        e = exp_q.pop_front();
        check("task_ctl", 256'(dut_ctl()), 256'({e.op, e.warp, e.rd, e.grp, e.lmask, e.last}));
        check("task_rs1", out_rs1, e.rs1);
        check("task_rs2", out_rs2, e.rs2);
        check("task_rs3", out_rs3, e.rs3);
      end
      stall_prev = out_valid && !out_ready;
      prev_ctl   = dut_ctl();
      prev_rs1   = out_rs1;
      prev_rs2   = out_rs2;
      prev_rs3   = out_rs3;
      if (in_valid && in_ready) model_push();
    end
  end

  // out_ready driver: random backpressure or a directed level
  always @(posedge clk) begin
    #2;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
  end

  // Present an entry and hold it until accepted; returns at posedge+1
  task automatic send(input logic [TN-1:0] m, input bit seq);
    int n = 0;
    in_mask     = m;
    in_op       = 5'($urandom);
    in_warp_num = 5'($urandom);
    in_rd       = 5'($urandom);
    for (int t = 0; t < TN; t++) begin
      in_rs1[t*DW +: DW] = seq ? 32'(t) : $urandom;
      in_rs2[t*DW +: DW] = $urandom;
      in_rs3[t*DW +: DW] = $urandom;
    end
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!(in_ready && !rst) && n < 1000);
    if (n >= 1000) timeout_fail("send_accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) timeout_fail("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_group(input logic [1:0] g);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_group == g) && n < 200);
    if (n >= 200) timeout_fail("wait_group");
  endtask

  initial begin
    logic [TN-1:0] m;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_mask = '0; in_op = '0; in_warp_num = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
    #2;
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_ctl", 256'(dut_ctl()), 256'(0));
    check("rst_rs1", out_rs1, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Full mask with thread-index data, no backpressure
    forced_ready = 1'b1;
    send(32'hFFFF_FFFF, 1'b1);
    drain();

    // Sparse mask: groups 1 and 3 skipped
    send(32'h00FF_0001, 1'b1);
    drain();

    // Empty mask: consumed, nothing issued
    send(32'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("mask0_in_ready", 256'(in_ready), 256'(1));
    check("mask0_out_valid", 256'(out_valid), 256'(0));
    @(posedge clk);
    #1;

    // Stall five cycles on group 1
    forced_ready = 1'b0;
    send(32'hFFFF_FFFF, 1'b1);
    wait_group(2'd0);
    @(posedge clk); #1; forced_ready = 1'b1;
    @(posedge clk); #1; forced_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stall_group", 256'({out_valid, out_group}), 256'({1'b1, 2'd1}));
    @(posedge clk); #1; forced_ready = 1'b1;
    drain();

    // Asynchronous reset while issuing group 2
    send(32'hFFFF_FFFF, 1'b0);
    wait_group(2'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 256'(out_valid), 256'(0));
    check("async_rst_ready", 256'(in_ready), 256'(1));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(32'h8000_FF00, 1'b0);
    drain();

    // Second entry waiting while the first issues
    rnd_ready = 1'b1;
    send(32'h0F0F_0F0F, 1'b0);
    send(32'hF000_000F, 1'b0);
    drain();

    // Randomized entries and backpressure
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: m = 32'hFFFF_FFFF;
        1: m = 32'h0;
        2: m = $urandom;
        default: begin
          m = $urandom & $urandom;
          for (int g = 0; g < G; g++) if ($urandom_range(0, 1) == 1) m[g*L +: L] = '0;
        end
      endcase
      send(m, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
